// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between instruction fetch and load/store, data-first with fetch starvation guard
// Ports: clk/reset (async, active-high); i_req/i_addr -> i_ack/i_rdata (fetch side);
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata (data side); m_raddr/m_waddr/m_wdata/m_wr/m_rdata (memory);
//   busy (state != IDLE), owner_d (data side owns the port).
// Optional: define MEM_ARB_PERF_CNT_EN to add perf_i_grants, perf_d_grants, perf_stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic [ADDR_W-1:0] m_raddr,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [63:0]       m_wdata,
  output logic              m_wr,
  input  logic [63:0]       m_rdata,
  output logic              busy,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall,
`endif
  output logic              owner_d
);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state;
  logic [LW-1:0]     lat_cnt;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic              we_q;
  logic              gnt_d, gnt_i, acc;
  // fetch overrides data only once it has lost STARVE_MAX consecutive contests
  assign gnt_d   = state == IDLE && d_req && (!i_req || starve_cnt != SW'(STARVE_MAX));
  assign gnt_i   = state == IDLE && i_req && !gnt_d;
  assign acc     = state == ACCESS;
  assign busy    = state != IDLE;
  // memory lines are decoded from state so an async reset drops them at once
  assign m_raddr = acc ? addr_q : '0;
  assign m_waddr = acc ? addr_q : '0;
  assign m_wdata = acc ? wdata_q : '0;
  assign m_wr    = acc && we_q && lat_cnt == LW'(RD_LAT);
  assign i_ack   = state == RESP && !owner_d;
  assign d_ack   = state == RESP && owner_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_d    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: if (gnt_d || gnt_i) begin
          state      <= ACCESS;
          lat_cnt    <= LW'(RD_LAT);
          owner_d    <= gnt_d;
          addr_q     <= gnt_d ? d_addr : i_addr;
          we_q       <= gnt_d && d_we;
          wdata_q    <= gnt_d ? d_wdata : '0;
          starve_cnt <= gnt_i ? '0 :
                        (i_req && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
        end
        ACCESS: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LW'(1)) begin
            state <= RESP;
            if (!owner_d) i_rdata <= addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
            else if (!we_q) d_rdata <= m_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_ARB_PERF_CNT_EN
  logic stall;
  assign stall = (i_req && !(busy && !owner_d)) || (d_req && !(busy && owner_d));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_stall    <= '0;
    end else begin
      perf_i_grants <= perf_i_grants + 32'(gnt_i);
      perf_d_grants <= perf_d_grants + 32'(gnt_d);
      perf_stall    <= perf_stall + 32'(stall);
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic        i_ack, d_ack, m_wr, busy, owner_d;
  logic [31:0] i_rdata;
  logic [63:0] d_rdata, m_raddr, m_waddr, m_wdata;
  logic        i_ack3, d_ack3, m_wr3, busy3, owner_d3;
  logic [31:0] i_rdata3;
  logic [63:0] d_rdata3, m_raddr3, m_waddr3, m_wdata3;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pi, pd, ps, pi3, pd3, ps3, pi0, pd0, ps0;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rdata(m_rdata),
    .busy(busy),
`ifdef MEM_ARB_PERF_CNT_EN
    .perf_i_grants(pi), .perf_d_grants(pd), .perf_stall(ps),
`endif
    .owner_d(owner_d));

  mem_port_arbiter #(.ADDR_W(64), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .m_raddr(m_raddr3), .m_waddr(m_waddr3), .m_wdata(m_wdata3), .m_wr(m_wr3), .m_rdata(m_rdata),
    .busy(busy3),
`ifdef MEM_ARB_PERF_CNT_EN
    .perf_i_grants(pi3), .perf_d_grants(pd3), .perf_stall(ps3),
`endif
    .owner_d(owner_d3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        dr;
    logic        dw;
    logic [63:0] da;
    logic [63:0] dwd;
    logic [63:0] mr;
    logic        ed;
    logic [31:0] eir;
    logic [63:0] edr;
    int          ew;
  } vec_t;
  vec_t v[7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wr, n, bc, acks;
    logic got[10];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_m", {m_wr, m_raddr, m_waddr, m_wdata}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_owner", owner_d, 0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    v[0] = '{1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 64'h0, 64'hAABBCCDD_11223344, 1'b0, 32'hAABBCCDD, 64'h0, 0};
    v[1] = '{1'b1, 64'h8, 1'b0, 1'b0, 64'h0, 64'h0, 64'hAABBCCDD_11223344, 1'b0, 32'h11223344, 64'h0, 0};
    v[2] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0, 64'h01234567_89ABCDEF, 1'b1, 32'h11223344, 64'h01234567_89ABCDEF, 0};
    v[3] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 64'h1234, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'h11223344, 64'h01234567_89ABCDEF, 1};
    v[4] = '{1'b1, 64'h4, 1'b1, 1'b0, 64'h20, 64'h0, 64'hCAFEF00D_5555AAAA, 1'b1, 32'h11223344, 64'hCAFEF00D_5555AAAA, 0};
    v[5] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'hFFFF0000_00000018, 64'h0, 64'h1, 1'b1, 32'h11223344, 64'h1, 0};
    v[6] = '{1'b1, 64'h80000000_0000000C, 1'b0, 1'b0, 64'h0, 64'h0, 64'h77778888_99990000, 1'b0, 32'h77778888, 64'h1, 0};
    for (int i = 0; i < 7; i++) begin
      i_req = v[i].ir; i_addr = v[i].ia; d_req = v[i].dr; d_we = v[i].dw;
      d_addr = v[i].da; d_wdata = v[i].dwd; m_rdata = v[i].mr;
      lat = 0; wr = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        @(posedge clk); #1;
        if (m_wr) begin
          wr++;
          chk($sformatf("v%0d_waddr", i), m_waddr, v[i].da);
          chk($sformatf("v%0d_raddr", i), m_raddr, v[i].da);
          chk($sformatf("v%0d_wdata", i), m_wdata, v[i].dwd);
        end
        if (i_ack || d_ack) begin
          lat = k;
          chk($sformatf("v%0d_d_ack", i), d_ack, v[i].ed);
          chk($sformatf("v%0d_i_ack", i), i_ack, !v[i].ed);
          chk($sformatf("v%0d_owner", i), owner_d, v[i].ed);
          chk($sformatf("v%0d_i_rdata", i), i_rdata, v[i].eir);
          chk($sformatf("v%0d_d_rdata", i), d_rdata, v[i].edr);
          chk($sformatf("v%0d_m_idle", i), {m_wr, m_raddr, m_wdata}, 0);
        end
      end
      i_req = 0; d_req = 0; d_we = 0;
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_wr_pulses", i), wr, v[i].ew);
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    repeat (6) @(posedge clk);
    #1;
    // both requesters held continuously: expect D,D,D,D,I,D,D,D,D,I
`ifdef MEM_ARB_PERF_CNT_EN
    pi0 = pi; pd0 = pd; ps0 = ps;
`endif
    i_req = 1; d_req = 1; d_we = 0; i_addr = 64'h4; d_addr = 64'h40; m_rdata = 64'h5;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(posedge clk); #1;
      if (d_ack) begin
        got[n] = 1; n++;
      end else if (i_ack) begin
        got[n] = 0; n++;
        chk($sformatf("starve_clr%0d", n), dut.starve_cnt, 0);
      end
      if (n == 10) begin
        i_req = 0; d_req = 0;
      end
    end
    i_req = 0; d_req = 0;
    chk("sim_grants", n, 10);
    for (int j = 0; j < 10; j++) chk($sformatf("order%0d", j), got[j], !(j == 4 || j == 9));
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_d", pd - pd0, 8);
    chk("perf_i", pi - pi0, 2);
    chk("perf_stall_pos", (ps - ps0) > 0, 1);
`endif
    repeat (8) @(posedge clk);
    #1;
    chk("l3_pre_idle", busy3, 0);
    // RD_LAT=3 load: data becomes valid in the third ACCESS cycle
    d_req = 1; d_we = 0; d_addr = 64'h8; m_rdata = 64'h0;
    lat = 0; bc = 0; acks = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (busy3) bc++;
      if (i_ack3) acks++;
      if (k == 2) m_rdata = 64'hDEADBEEF;
      if (d_ack3 && lat == 0) begin
        lat = k; d_req = 0;
        chk("l3_d_rdata", d_rdata3, 64'hDEADBEEF);
      end
    end
    chk("l3_latency", lat, 4);
    chk("l3_busy_cycles", bc, 4);
    chk("l3_no_i_ack", acks, 0);
    repeat (4) @(posedge clk);
    #1;
    // reset in the first ACCESS cycle of a store
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'h55;
    @(posedge clk); #1;
    chk("rs_pre_wr", m_wr, 1);
    chk("rs_pre_waddr", m_waddr, 64'h200);
    reset = 1; d_req = 0; d_we = 0;
    #1;
    chk("rs_wr_drop", m_wr, 0);
    chk("rs_busy_drop", busy, 0);
    @(negedge clk) reset = 0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (d_ack || i_ack) acks++;
    end
    chk("rs_no_ack", acks, 0);
    chk("rs_busy", busy, 0);
    chk("rs_m", {m_wr, m_raddr, m_waddr, m_wdata}, 0);
    chk("rs_rdata", {i_rdata, d_rdata}, 0);
    chk("rs_owner", owner_d, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit memory port between the instruction-fetch path (PC → fetch) and the load/store path (ALUOut address, Store-unit write data) of the multicycle RISC-V core.
- Each side uses a req/ack handshake. The arbiter serialises accesses, drives the memory control lines and returns read data.
- Default priority goes to data. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width of both requesters and the memory.
- RD_LAT, 1, memory read latency in cycles; minimum 1. Sets the length of the ACCESS state.
- STARVE_MAX, 4, number of consecutive data grants taken while a fetch waits; after this many, the fetch wins.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; level, held until i_ack
- i_addr  in  ADDR_W  fetch byte address
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  32  fetched word; m_rdata[63:32] if addr[2]=1, else m_rdata[31:0]
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  64  store data (already merged by the Store unit)
- d_ack  out  1  one-cycle pulse; d_rdata valid when d_we=0
- d_rdata  out  64  load data
- m_raddr  out  ADDR_W  memory read address
- m_waddr  out  ADDR_W  memory write address
- m_wdata  out  64  memory write data
- m_wr  out  1  memory write enable
- m_rdata  in  64  memory read data; valid RD_LAT cycles after address
- busy  out  1  1 when the state is not IDLE
- owner_d  out  1  1 while the data side owns the port

Behaviour:
- Reset (asynchronous): state=IDLE, starve_cnt=0, lat_cnt=0.
  - All outputs 0: acks, rdata registers, m_* outputs, busy, owner_d.
  - Reset during ACCESS aborts the transaction. m_wr falls immediately because it is decoded from state. No ack is issued after reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - m_* outputs are 0.
  - Requests are sampled at each rising edge.
  - Only one request high: that side is granted.
  - Both high: data is granted, unless starve_cnt==STARVE_MAX, in which case fetch is granted.
  - On grant: latch the address, plus we/wdata for the data side. Set owner_d. Load lat_cnt=RD_LAT. Go to ACCESS.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on a data grant while i_req=1.
  - Clears on any fetch grant.
  - Otherwise holds.
- ACCESS:
  - m_raddr and m_waddr = latched address. m_wdata = latched wdata.
  - m_wr=1 only in the first ACCESS cycle, and only for a store.
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt==1: capture m_rdata into the selected rdata register (skipped for a store; d_rdata holds its previous value) and go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle. m_* outputs are 0. Next state is IDLE.
  - Request-to-ack latency is RD_LAT+1 cycles after the sampling edge. Back-to-back grants are spaced RD_LAT+2 cycles apart.
- Requester rules:
  - A requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
  - Dropping req mid-transaction has no effect: the access completes and ack still pulses.
  - Address and data changes after grant are ignored.
- The non-owner's ack stays 0 throughout. Its req is held pending with no timeout.
- busy = (state != IDLE). owner_d is valid while busy and holds its last value in IDLE.
- Address bits above the memory depth are passed through unchanged; aliasing is the memory's concern.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all reset to 0 and wrapping modulo 2^32:
  - perf_i_grants: number of fetch grants.
  - perf_d_grants: number of data grants.
  - perf_stall: cycles where any req is high and that requester is not the current owner, including all IDLE-arbitration losses.
- When undefined, these ports and their counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Fetch only, RD_LAT=1: i_req=1, i_addr=0x4, m_rdata=0xAABBCCDD_11223344 → i_ack high 2 cycles after the sampling edge; i_rdata=0xAABBCCDD; m_wr=0 throughout.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1234 → m_wr=1 for exactly one cycle with m_waddr=0x100 and m_wdata=0x1234; d_ack pulses once; d_rdata unchanged.
- Simultaneous requests: i_req and d_req both held continuously (data re-requests after every ack), STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- RD_LAT=3 load: d_addr=0x8, m_rdata=0xDEAD_BEEF valid 3 cycles after address → d_ack 4 cycles after the sampling edge; d_rdata=0xDEADBEEF; busy high for 4 cycles.
- Reset asserted in the first ACCESS cycle of a store → m_wr drops in the same cycle; no d_ack; after release, state=IDLE and all outputs are 0.
- MEM_ARB_PERF_CNT_EN defined, run the simultaneous-request case for 10 grants → perf_d_grants=8, perf_i_grants=2, perf_stall>0.
